// File: rtl/branch_flush_unit_pkg.sv
// Shared definitions for branch prediction and flush control.
// Holds the next-PC select encodings and the counter reset-value helper.
package bp_pkg;

    localparam logic [1:0] PC_SRC_SEQ     = 2'b00;
    localparam logic [1:0] PC_SRC_ID_TGT  = 2'b01;
    localparam logic [1:0] PC_SRC_EX_TGT  = 2'b10;
    localparam logic [1:0] PC_SRC_EX_FALL = 2'b11;

    // Weakly not-taken: the largest value whose MSB is still clear.
    function automatic int unsigned ctr_rst_val(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_flush_unit_sat_counter.sv
// Saturating up/down counter with a synchronous load.
// Exposes the next value so callers can bypass a same-cycle update.
module sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] nxt_o
);

    localparam logic [W-1:0] MAX = '1;

    // Next value: load wins, then inc/dec clamped at the rails.
    always_comb begin
        nxt_o = q_o;
        if (load_i) begin
            nxt_o = load_val_i;
        end else if (inc_i && !dec_i && q_o != MAX) begin
            nxt_o = q_o + W'(1);
        end else if (dec_i && !inc_i && q_o != '0) begin
            nxt_o = q_o - W'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i) begin
        q_o <= nxt_o;
    end

endmodule

// File: rtl/branch_flush_unit.sv
// Branch predictor table, EX resolution and pipeline flush control.
// Table is a flop array so ID can read it combinationally with bypass.
module branch_flush_unit
    import bp_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CTR_W = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_branch_i,
    input  logic [PC_W-1:0]  id_pc_i,
    output logic             id_predict_o,
    input  logic             ex_branch_i,
    input  logic [PC_W-1:0]  ex_pc_i,
    input  logic             ex_predict_i,
    input  logic             ex_zero_i,
    output logic             if_flush_o,
    output logic             id_flush_o,
    output logic [1:0]       pc_src_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    localparam int unsigned N = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_rst_val(CTR_W));

    logic [IDX_W-1:0] id_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [CTR_W-1:0] tbl_q   [N];
    logic [CTR_W-1:0] tbl_nxt [N];
    logic [CTR_W-1:0] id_ctr;
    logic             ex_upd;
    logic             mispredict;
    logic [CNT_W-1:0] br_nxt;
    logic [CNT_W-1:0] mis_nxt;
    logic             unused;

    assign id_idx = id_pc_i[IDX_W+1:2];
    assign ex_idx = ex_pc_i[IDX_W+1:2];
    assign ex_upd = ex_branch_i & ~rst_i;

    for (genvar i = 0; i < N; i++) begin : g_tbl
        sat_counter #(.W(CTR_W)) u_ctr (
            .clk_i      (clk_i),
            .load_i     (rst_i),
            .load_val_i (CTR_RST),
            .inc_i      (ex_upd & (ex_idx == IDX_W'(i)) & ex_zero_i),
            .dec_i      (ex_upd & (ex_idx == IDX_W'(i)) & ~ex_zero_i),
            .q_o        (tbl_q[i]),
            .nxt_o      (tbl_nxt[i])
        );
    end

    // Same-index EX training is forwarded to the ID lookup.
    always_comb begin
        id_ctr = tbl_q[id_idx];
        if (ex_upd && ex_idx == id_idx) begin
            id_ctr = tbl_nxt[ex_idx];
        end
    end

    assign id_predict_o = ~rst_i & id_branch_i & id_ctr[CTR_W-1];
    assign mispredict   = ex_upd & (ex_predict_i ^ ex_zero_i);
    assign id_flush_o   = mispredict;
    assign if_flush_o   = mispredict | id_predict_o;

    // Next-PC select: an EX mispredict overrides the ID prediction.
    always_comb begin
        pc_src_o = PC_SRC_SEQ;
        if (mispredict) begin
            pc_src_o = ex_zero_i ? PC_SRC_EX_TGT : PC_SRC_EX_FALL;
        end else if (id_predict_o) begin
            pc_src_o = PC_SRC_ID_TGT;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk_i      (clk_i),
        .load_i     (rst_i),
        .load_val_i ('0),
        .inc_i      (ex_branch_i),
        .dec_i      (1'b0),
        .q_o        (branch_cnt_o),
        .nxt_o      (br_nxt)
    );

    sat_counter #(.W(CNT_W)) u_mis_cnt (
        .clk_i      (clk_i),
        .load_i     (rst_i),
        .load_val_i ('0),
        .inc_i      (mispredict),
        .dec_i      (1'b0),
        .q_o        (mispredict_cnt_o),
        .nxt_o      (mis_nxt)
    );

    assign unused = ^{id_pc_i[PC_W-1:IDX_W+2], id_pc_i[1:0],
                      ex_pc_i[PC_W-1:IDX_W+2], ex_pc_i[1:0],
                      br_nxt, mis_nxt};

endmodule

// File: tb/tb_branch_flush_unit.sv
// Randomised and directed bench for branch_flush_unit.
// A second instance with 3-bit statistics exercises counter saturation.
module tb_branch_flush_unit;

    logic        clk = 1'b0;
    logic        rst_i, id_branch_i, ex_branch_i, ex_predict_i, ex_zero_i;
    logic [31:0] id_pc_i, ex_pc_i;
    logic        id_predict_o, if_flush_o, id_flush_o;
    logic [1:0]  pc_src_o;
    logic [15:0] branch_cnt_o, mispredict_cnt_o;
    logic        s_pred, s_if, s_id;
    logic [1:0]  s_src;
    logic [2:0]  s_br, s_mis;

    int mctr [16];
    int mbr, mmis, mbr3, mmis3;
    bit exp_pred, exp_if, exp_id;
    int exp_src;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    branch_flush_unit dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_branch_i(id_branch_i), .id_pc_i(id_pc_i),
        .id_predict_o(id_predict_o),
        .ex_branch_i(ex_branch_i), .ex_pc_i(ex_pc_i),
        .ex_predict_i(ex_predict_i), .ex_zero_i(ex_zero_i),
        .if_flush_o(if_flush_o), .id_flush_o(id_flush_o),
        .pc_src_o(pc_src_o),
        .branch_cnt_o(branch_cnt_o),
        .mispredict_cnt_o(mispredict_cnt_o)
    );

    branch_flush_unit #(.CNT_W(3)) dut_s (
        .clk_i(clk), .rst_i(rst_i),
        .id_branch_i(id_branch_i), .id_pc_i(id_pc_i),
        .id_predict_o(s_pred),
        .ex_branch_i(ex_branch_i), .ex_pc_i(ex_pc_i),
        .ex_predict_i(ex_predict_i), .ex_zero_i(ex_zero_i),
        .if_flush_o(s_if), .id_flush_o(s_id),
        .pc_src_o(s_src),
        .branch_cnt_o(s_br),
        .mispredict_cnt_o(s_mis)
    );

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit model_mis();
        return !rst_i && ex_branch_i && (ex_predict_i != ex_zero_i);
    endfunction

    function automatic int trained(input int v, input bit taken);
        if (taken) return (v + 1 > 3) ? 3 : v + 1;
        return (v - 1 < 0) ? 0 : v - 1;
    endfunction

    // Expected combinational outputs for the current inputs.
    function automatic void model_eval();
        int  v;
        bit  mis;
        mis = model_mis();
        v = mctr[idx_of(id_pc_i)];
        if (!rst_i && ex_branch_i && idx_of(ex_pc_i) == idx_of(id_pc_i))
            v = trained(v, ex_zero_i);
        exp_pred = !rst_i && id_branch_i && v >= 2;
        exp_id   = mis;
        exp_if   = mis || exp_pred;
        exp_src  = mis ? (ex_zero_i ? 2 : 3) : (exp_pred ? 1 : 0);
    endfunction

    task automatic tick();
        bit mis;
        mis = model_mis();
        @(posedge clk);
        if (rst_i) begin
            for (int i = 0; i < 16; i++) mctr[i] = 1;
            mbr = 0; mmis = 0; mbr3 = 0; mmis3 = 0;
        end else if (ex_branch_i) begin
            mctr[idx_of(ex_pc_i)] = trained(mctr[idx_of(ex_pc_i)], ex_zero_i);
            mbr  = (mbr  < 65535) ? mbr + 1 : mbr;
            mbr3 = (mbr3 < 7) ? mbr3 + 1 : mbr3;
            if (mis) begin
                mmis  = (mmis  < 65535) ? mmis + 1 : mmis;
                mmis3 = (mmis3 < 7) ? mmis3 + 1 : mmis3;
            end
        end
        #1;
    endtask

    task automatic drive(input bit r, input bit idb, input logic [31:0] idpc,
                         input bit exb, input logic [31:0] expc,
                         input bit prd, input bit z);
        rst_i = r; id_branch_i = idb; id_pc_i = idpc;
        ex_branch_i = exb; ex_pc_i = expc;
        ex_predict_i = prd; ex_zero_i = z;
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h10, 1, 32'h10, 0, 1);
        n_total++;
        if ({id_predict_o, if_flush_o, id_flush_o, pc_src_o} !== 5'b0)
            $display("FAIL reset_outs got %b want 00000",
                     {id_predict_o, if_flush_o, id_flush_o, pc_src_o});
        else n_pass++;
        tick();
        drive(0, 1, 32'h10, 0, 32'h0, 0, 0);
        n_total++;
        if ({branch_cnt_o, mispredict_cnt_o} !== 32'h0)
            $display("FAIL reset_cnts got %h/%h want 0/0",
                     branch_cnt_o, mispredict_cnt_o);
        else n_pass++;
        n_total++;
        if ({id_predict_o, if_flush_o, pc_src_o} !== 4'b0000)
            $display("FAIL fresh_lookup got %b want 0000",
                     {id_predict_o, if_flush_o, pc_src_o});
        else n_pass++;
        tick();
    endtask

    task automatic test_train();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 32'h0, 1, 32'h10, 0, 1);
            n_total++;
            if (id_flush_o !== 1'b1 || pc_src_o !== 2'b10)
                $display("FAIL train_res%0d got flush=%b src=%b want 1/10",
                         k, id_flush_o, pc_src_o);
            else n_pass++;
            tick();
        end
        drive(0, 1, 32'h10, 0, 32'h0, 0, 0);
        n_total++;
        if ({id_predict_o, if_flush_o, pc_src_o} !== 4'b1101)
            $display("FAIL train_lookup got %b want 1101",
                     {id_predict_o, if_flush_o, pc_src_o});
        else n_pass++;
        n_total++;
        if (branch_cnt_o !== 16'd2 || mispredict_cnt_o !== 16'd2)
            $display("FAIL train_cnts got %0d/%0d want 2/2",
                     branch_cnt_o, mispredict_cnt_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 32'h0, 1, 32'h10, 1, 1);
            tick();
        end
        drive(0, 0, 32'h0, 1, 32'h50, 1, 0);
        n_total++;
        if (pc_src_o !== 2'b11 || id_flush_o !== 1'b1)
            $display("FAIL sat_alias_mis got src=%b flush=%b want 11/1",
                     pc_src_o, id_flush_o);
        else n_pass++;
        tick();
        drive(0, 1, 32'h10, 0, 32'h0, 0, 0);
        n_total++;
        if (id_predict_o !== 1'b1)
            $display("FAIL sat_hold got %b want 1", id_predict_o);
        else n_pass++;
        tick();
        drive(0, 0, 32'h0, 1, 32'h50, 1, 0);
        tick();
        drive(0, 1, 32'h10, 0, 32'h0, 0, 0);
        n_total++;
        if (id_predict_o !== 1'b0)
            $display("FAIL sat_alias_drop got %b want 0", id_predict_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_same_cycle();
        drive(0, 0, 32'h0, 1, 32'h30, 0, 1);
        tick();
        drive(0, 1, 32'h30, 1, 32'h20, 1, 0);
        n_total++;
        if ({if_flush_o, id_flush_o, pc_src_o} !== 4'b1111)
            $display("FAIL same_cycle got %b want 1111",
                     {if_flush_o, id_flush_o, pc_src_o});
        else n_pass++;
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 32'h0, 1, 32'h20, 0, 1);
            tick();
        end
        drive(0, 1, 32'h20, 1, 32'h20, 1, 0);
        n_total++;
        if ({id_predict_o, pc_src_o} !== 3'b011)
            $display("FAIL bypass_dec got %b want 011",
                     {id_predict_o, pc_src_o});
        else n_pass++;
        tick();
        drive(0, 1, 32'h20, 1, 32'h20, 0, 1);
        n_total++;
        if ({id_predict_o, if_flush_o, pc_src_o} !== 4'b1110)
            $display("FAIL bypass_inc got %b want 1110",
                     {id_predict_o, if_flush_o, pc_src_o});
        else n_pass++;
        tick();
    endtask

    task automatic test_stats();
        drive(1, 0, 32'h0, 0, 32'h0, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            if (k < 4) drive(0, 0, 32'h0, 1, 32'(k * 4), 0, 1);
            else drive(0, 0, 32'h0, 1, 32'(k * 4), k[0], k[0]);
            tick();
        end
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
        n_total++;
        if (s_br !== 3'd7 || s_mis !== 3'd4)
            $display("FAIL stats_sat got %0d/%0d want 7/4", s_br, s_mis);
        else n_pass++;
        n_total++;
        if (branch_cnt_o !== 16'd10 || mispredict_cnt_o !== 16'd4)
            $display("FAIL stats_wide got %0d/%0d want 10/4",
                     branch_cnt_o, mispredict_cnt_o);
        else n_pass++;
        drive(1, 1, 32'h0, 1, 32'h0, 0, 1);
        tick();
        drive(0, 1, 32'h0, 0, 32'h0, 0, 0);
        n_total++;
        if ({s_br, s_mis, branch_cnt_o, mispredict_cnt_o} !== 38'h0)
            $display("FAIL stats_rst got %0d/%0d/%0d/%0d want 0/0/0/0",
                     s_br, s_mis, branch_cnt_o, mispredict_cnt_o);
        else n_pass++;
        n_total++;
        if (id_predict_o !== 1'b0)
            $display("FAIL rst_tbl0 got %b want 0", id_predict_o);
        else n_pass++;
        tick();
        drive(0, 1, 32'h4, 0, 32'h0, 0, 0);
        n_total++;
        if (id_predict_o !== 1'b0)
            $display("FAIL rst_tbl1 got %b want 0", id_predict_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int k = 0; k < 3000; k++) begin
            a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 1) * 64);
            b = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 1) * 64);
            drive($urandom_range(0, 49) == 0, 1'($urandom), a,
                  1'($urandom), b, 1'($urandom), 1'($urandom));
            n_total++;
            if (id_predict_o !== exp_pred || if_flush_o !== exp_if ||
                id_flush_o !== exp_id || pc_src_o !== 2'(exp_src))
                $display("FAIL rnd_outs k=%0d got %b%b%b%b want %b%b%b%b",
                         k, id_predict_o, if_flush_o, id_flush_o, pc_src_o,
                         exp_pred, exp_if, exp_id, 2'(exp_src));
            else n_pass++;
            n_total++;
            if ({s_pred, s_if, s_id, s_src} !==
                {exp_pred, exp_if, exp_id, 2'(exp_src)})
                $display("FAIL rnd_outs_s k=%0d got %b%b%b%b", k,
                         s_pred, s_if, s_id, s_src);
            else n_pass++;
            n_total++;
            if (branch_cnt_o !== 16'(mbr) || mispredict_cnt_o !== 16'(mmis) ||
                s_br !== 3'(mbr3) || s_mis !== 3'(mmis3))
                $display("FAIL rnd_cnts k=%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         k, branch_cnt_o, mispredict_cnt_o, s_br, s_mis,
                         mbr, mmis, mbr3, mmis3);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_train();
        test_saturation();
        test_same_cycle();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_flush_unit.md
# branch_flush_unit

Parametrised branch prediction and flush control for the 5-stage pipeline. It holds a table of saturating counters indexed by PC and gives a taken/not-taken prediction for the branch in ID. It resolves the branch in EX against the actual outcome, trains the table, and drives IF/ID and ID/EX flushes plus the PC-source select. It also keeps saturating branch and mispredict statistics counters.

## Interface
Parameters:
- PC_W, 32, PC width.
- IDX_W, 4, table index width; table has 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- CTR_W, 2, saturating counter width; must be ≥ 1.
- CNT_W, 16, statistics counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- id_branch_i  in  1  the instruction in ID is a conditional branch.
- id_pc_i  in  PC_W  PC of the instruction in ID.
- id_predict_o  out  1  prediction for the ID branch (1 = taken).
- ex_branch_i  in  1  the instruction in EX is a branch; high for exactly one cycle per branch.
- ex_pc_i  in  PC_W  PC of the EX branch.
- ex_predict_i  in  1  prediction carried down from ID for the EX branch.
- ex_zero_i  in  1  actual outcome of the EX branch (1 = taken).
- if_flush_o  out  1  flush IF/ID.
- id_flush_o  out  1  flush ID/EX.
- pc_src_o  out  2  next-PC select; encodings are listed under Operation.
- branch_cnt_o  out  CNT_W  number of resolved branches.
- mispredict_cnt_o  out  CNT_W  number of mispredicted branches.

## Operation
- Counter reset value is 2^(CTR_W-1)-1 (weakly not-taken).
- The prediction is the counter MSB. id_predict_o = id_branch_i & MSB(table[idx(id_pc_i)]).
- Training on ex_branch_i:
  - ex_zero_i=1: the counter at idx(ex_pc_i) increments and saturates at 2^CTR_W-1.
  - ex_zero_i=0: the counter decrements and saturates at 0.
- Mispredict: mispredict = ex_branch_i & (ex_predict_i ^ ex_zero_i).
- Flush outputs:
  - id_flush_o = mispredict.
  - if_flush_o = mispredict | id_predict_o.
- pc_src_o encodings, highest priority first:
  - 2'b10 (EX target): mispredict and ex_zero_i=1.
  - 2'b11 (EX fall-through, ex_pc_i+4, computed externally): mispredict and ex_zero_i=0.
  - 2'b01 (ID predicted target): id_predict_o.
  - 2'b00 (sequential): otherwise.
- An EX mispredict overrides the ID prediction in the same cycle. The ID branch is squashed by id_flush_o, and pc_src_o follows EX.
- branch_cnt_o increments on each ex_branch_i. mispredict_cnt_o increments on each mispredict. Both saturate at all-ones and never wrap.

## Timing
- Prediction is combinational, with zero-cycle latency from id_pc_i/id_branch_i.
- Flush and pc_src outputs are combinational from the current inputs.
- Table and statistics updates take effect at the next rising edge.
- Same-cycle EX update and ID lookup to the same index: ID uses the post-update (bypassed) counter value.
- While rst_i=1:
  - id_predict_o, if_flush_o, id_flush_o and pc_src_o are forced to 0.
  - At the edge, every counter reloads the reset value, and both statistics counters load 0.
- Reset asserted mid-operation discards any pending update in that cycle.
- In the first cycle after reset, behaviour is as for a fresh table.

## Structure
- Shared package bp_pkg holds:
  - PC_SRC_SEQ/ID_TGT/EX_TGT/EX_FALL localparams.
  - The counter reset-value function of CTR_W.
- Sub-module sat_counter(CTR_W): inc/dec/load with saturation. It is instantiated per table entry and reused, with a wider width and inc-only, for the statistics counters.
- The table is a flop array, not a RAM, to allow the combinational read and bypass.

## Test plan
- Reset, then an ID branch at pc 0x10 → id_predict_o=0, if_flush_o=0, pc_src_o=00.
- Two EX taken resolutions of pc 0x10 (ex_predict_i=0), then an ID lookup of 0x10:
  - Each resolution cycle: mispredict, id_flush_o=1, pc_src_o=10.
  - Lookup: id_predict_o=1, if_flush_o=1, pc_src_o=01.
- Saturation: five taken resolutions leave the counter at 3; one not-taken then still predicts taken. The index aliases at pc 0x10 and 0x50 (IDX_W=4) share one counter.
- Same cycle:
  - Inputs: EX mispredict (pred=1, zero=0) at 0x20, and ID predict-taken at 0x30.
  - Required: if_flush_o=1, id_flush_o=1, pc_src_o=11.
  - Also verify the bypass: an ID lookup of 0x20 in that cycle sees the decremented value.
- Statistics with CNT_W=3: ten branches, four mispredicted → branch_cnt_o=7 (saturated), mispredict_cnt_o=4. Then assert rst_i mid-burst → both 0 next cycle and the table reinitialised.
